// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: one prioritized FSM producing
// stage-register enables, flushes and NOP injection, plus a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int STALL_CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             dec_regA,
    input  logic [4:0]             dec_regB,
    input  logic                   dec_is_immediate,
    input  logic                   alu_mem_r_en,
    input  logic [4:0]             alu_regD,
    input  logic                   branch_taken,
    input  logic                   block_pipe_instr_cache,
    input  logic                   block_pipe_data_cache,
    output logic                   EN_REG_FETCH,
    output logic                   EN_REG_DECODE,
    output logic                   EN_REG_ALU,
    output logic                   EN_REG_MEM,
    output logic                   flush_fetch,
    output logic                   flush_decode,
    output logic                   inject_nop,
    output logic [2:0]             ctrl_state,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        LU_STALL = 3'd1,
        BR_FLUSH = 3'd2,
        DC_WAIT  = 3'd3,
        IC_WAIT  = 3'd4
    } state_t;

    localparam logic [2:0] LU_RELOAD = 3'(LOAD_USE_CYCLES - 1);
    localparam logic [2:0] BR_RELOAD = 3'(BR_FLUSH_CYCLES - 1);

    state_t state, state_nxt;
    state_t saved, saved_nxt;
    state_t eff_state;
    logic [2:0] cnt, cnt_nxt;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic load_use;
    logic en_f, en_d, en_a, en_m;
    logic fl_f, fl_d, nop;

    always_comb begin
        load_use = alu_mem_r_en && (alu_regD != 5'd0) &&
                   ((alu_regD == dec_regA) || (!dec_is_immediate && (alu_regD == dec_regB)));
    end

    always_comb begin
        // While D-blocked the counter is frozen in cnt; saved holds the interrupted state
        eff_state = (state == DC_WAIT) ? saved : state;
        en_f      = 1'b1;
        en_d      = 1'b1;
        en_a      = 1'b1;
        en_m      = 1'b1;
        fl_f      = 1'b0;
        fl_d      = 1'b0;
        nop       = 1'b0;
        state_nxt = RUN;
        cnt_nxt   = '0;
        saved_nxt = saved;

        if (block_pipe_data_cache) begin
            en_f      = 1'b0;
            en_d      = 1'b0;
            en_a      = 1'b0;
            en_m      = 1'b0;
            state_nxt = DC_WAIT;
            cnt_nxt   = cnt;
            if (state != DC_WAIT) begin
                saved_nxt = (state == LU_STALL || state == BR_FLUSH) ? state : RUN;
            end
        end else if (branch_taken) begin
            fl_f      = 1'b1;
            fl_d      = 1'b1;
            state_nxt = BR_FLUSH;
            cnt_nxt   = BR_RELOAD;
        end else if (eff_state == BR_FLUSH && cnt != '0) begin
            fl_f      = 1'b1;
            fl_d      = 1'b1;
            state_nxt = BR_FLUSH;
            cnt_nxt   = cnt - 3'd1;
        end else if (eff_state == LU_STALL && cnt != '0) begin
            en_f      = 1'b0;
            fl_d      = 1'b1;
            state_nxt = LU_STALL;
            cnt_nxt   = cnt - 3'd1;
        end else if ((eff_state == RUN || eff_state == IC_WAIT) && load_use) begin
            en_f      = 1'b0;
            fl_d      = 1'b1;
            state_nxt = LU_STALL;
            cnt_nxt   = LU_RELOAD;
        end else if (block_pipe_instr_cache) begin
            en_f      = 1'b0;
            nop       = 1'b1;
            state_nxt = IC_WAIT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            saved     <= RUN;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            saved <= saved_nxt;
            cnt   <= cnt_nxt;
            if (!en_f && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    // Outputs are held inactive for as long as reset is asserted
    assign EN_REG_FETCH  = !reset && en_f;
    assign EN_REG_DECODE = !reset && en_d;
    assign EN_REG_ALU    = !reset && en_a;
    assign EN_REG_MEM    = !reset && en_m;
    assign flush_fetch   = !reset && fl_f;
    assign flush_decode  = !reset && fl_d;
    assign inject_nop    = !reset && nop;
    assign ctrl_state    = state;
    assign stall_count   = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances (LOAD_USE_CYCLES=1 and 3,
// BR_FLUSH_CYCLES=2) share stimulus and are checked every cycle against a rule model.
module tb_pipeline_hazard_ctrl;

    localparam int SW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] dec_regA = '0, dec_regB = '0, alu_regD = '0;
    logic dec_is_immediate = 1'b0, alu_mem_r_en = 1'b0, branch_taken = 1'b0;
    logic block_pipe_instr_cache = 1'b0, block_pipe_data_cache = 1'b0;

    logic [1:0][3:0]    en;
    logic [1:0]         ff, fd, nop;
    logic [1:0][2:0]    st;
    logic [1:0][SW-1:0] sc;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(1), .BR_FLUSH_CYCLES(2), .STALL_CNT_W(SW)) u_a (
        .clk(clk), .reset(reset),
        .dec_regA(dec_regA), .dec_regB(dec_regB), .dec_is_immediate(dec_is_immediate),
        .alu_mem_r_en(alu_mem_r_en), .alu_regD(alu_regD), .branch_taken(branch_taken),
        .block_pipe_instr_cache(block_pipe_instr_cache), .block_pipe_data_cache(block_pipe_data_cache),
        .EN_REG_FETCH(en[0][3]), .EN_REG_DECODE(en[0][2]), .EN_REG_ALU(en[0][1]), .EN_REG_MEM(en[0][0]),
        .flush_fetch(ff[0]), .flush_decode(fd[0]), .inject_nop(nop[0]),
        .ctrl_state(st[0]), .stall_count(sc[0])
    );

    pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(3), .BR_FLUSH_CYCLES(2), .STALL_CNT_W(SW)) u_b (
        .clk(clk), .reset(reset),
        .dec_regA(dec_regA), .dec_regB(dec_regB), .dec_is_immediate(dec_is_immediate),
        .alu_mem_r_en(alu_mem_r_en), .alu_regD(alu_regD), .branch_taken(branch_taken),
        .block_pipe_instr_cache(block_pipe_instr_cache), .block_pipe_data_cache(block_pipe_data_cache),
        .EN_REG_FETCH(en[1][3]), .EN_REG_DECODE(en[1][2]), .EN_REG_ALU(en[1][1]), .EN_REG_MEM(en[1][0]),
        .flush_fetch(ff[1]), .flush_decode(fd[1]), .inject_nop(nop[1]),
        .ctrl_state(st[1]), .stall_count(sc[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Rule model: state code, remaining repeat count, state interrupted by a D-cache block
    typedef struct packed {
        logic [3:0]    en;
        logic          ff;
        logic          fd;
        logic          nop;
        logic [2:0]    st;
        logic [SW-1:0] sc;
    } obs_t;

    int lu_n [2] = '{1, 3};
    int br_n [2] = '{2, 2};
    int m_code [2] = '{0, 0};
    int m_left [2] = '{0, 0};
    int m_saved [2] = '{0, 0};
    int m_sc [2] = '{0, 0};
    int n_code [2] = '{0, 0};
    int n_left [2] = '{0, 0};
    int n_saved [2] = '{0, 0};
    logic [1:0] e_fetch = 2'b11;
    obs_t e;
    int eff;
    logic haz;

    always @(negedge clk) begin
        haz = alu_mem_r_en && alu_regD != 5'd0 &&
              (alu_regD == dec_regA || (!dec_is_immediate && alu_regD == dec_regB));
        for (int k = 0; k < 2; k++) begin
            e = '0;
            e.en = 4'hF;
            e.st = 3'(m_code[k]);
            e.sc = SW'(m_sc[k]);
            eff = (m_code[k] == 3) ? m_saved[k] : m_code[k];
            n_code[k] = 0;
            n_left[k] = 0;
            n_saved[k] = m_saved[k];
            if (reset) begin
                e = '0;
                n_saved[k] = 0;
            end else if (block_pipe_data_cache) begin
                e.en = 4'h0;
                n_code[k] = 3;
                n_left[k] = m_left[k];
                if (m_code[k] != 3) n_saved[k] = (m_code[k] == 1 || m_code[k] == 2) ? m_code[k] : 0;
            end else if (branch_taken || (eff == 2 && m_left[k] > 0)) begin
                e.ff = 1'b1;
                e.fd = 1'b1;
                n_code[k] = 2;
                n_left[k] = branch_taken ? br_n[k] - 1 : m_left[k] - 1;
            end else if ((eff == 1 && m_left[k] > 0) || ((eff == 0 || eff == 4) && haz)) begin
                e.en[3] = 1'b0;
                e.fd = 1'b1;
                n_code[k] = 1;
                n_left[k] = (eff == 1) ? m_left[k] - 1 : lu_n[k] - 1;
            end else if (block_pipe_instr_cache) begin
                e.en[3] = 1'b0;
                e.nop = 1'b1;
                n_code[k] = 4;
            end
            e_fetch[k] = e.en[3];
            chk($sformatf("en%0d", k), int'(en[k]), int'(e.en));
            chk($sformatf("flush_fetch%0d", k), int'(ff[k]), int'(e.ff));
            chk($sformatf("flush_decode%0d", k), int'(fd[k]), int'(e.fd));
            chk($sformatf("inject_nop%0d", k), int'(nop[k]), int'(e.nop));
            chk($sformatf("ctrl_state%0d", k), int'(st[k]), int'(e.st));
            chk($sformatf("stall_count%0d", k), int'(sc[k]), int'(e.sc));
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_code[k] <= 0;
                m_left[k] <= 0;
                m_saved[k] <= 0;
                m_sc[k] <= 0;
            end else begin
                if (!e_fetch[k] && m_sc[k] < (1 << SW) - 1) m_sc[k] <= m_sc[k] + 1;
                m_code[k] <= n_code[k];
                m_left[k] <= n_left[k];
                m_saved[k] <= n_saved[k];
            end
        end
    end

    task automatic cyc(input logic ld, input logic [4:0] rd, input logic [4:0] ra,
                       input logic [4:0] rb, input logic imm, input logic br,
                       input logic ic, input logic dc);
        @(posedge clk);
        #2;
        alu_mem_r_en = ld;
        alu_regD = rd;
        dec_regA = ra;
        dec_regB = rb;
        dec_is_immediate = imm;
        branch_taken = br;
        block_pipe_instr_cache = ic;
        block_pipe_data_cache = dc;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        #1;
        chk("rst_en_a", int'(en[0]), 0);
        chk("rst_sc_a", int'(sc[0]), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        idle(1);
        chk("run_en_a", int'(en[0]), 15);

        // Load-use on regA
        cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_fetch_a", int'(en[0][3]), 0);
        chk("lu_fd_a", int'(fd[0]), 1);
        idle(1);
        chk("lu_state_a", int'(st[0]), 1);
        chk("lu_sc_a", int'(sc[0]), 1);
        chk("lu_fetch_after_a", int'(en[0][3]), 1);
        idle(1);
        chk("lu_run_a", int'(st[0]), 0);
        idle(1);
        chk("lu_sc_b", int'(sc[1]), 3);
        idle(1);

        // Immediate masking and regD=0
        cyc(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("imm_mask_a", int'(en[0][3]), 1);
        cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("zero_reg_a", int'(en[0][3]), 1);
        cyc(1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("regb_haz_a", int'(en[0][3]), 0);
        idle(4);
        chk("mask_sc_a", int'(sc[0]), 2);
        chk("mask_sc_b", int'(sc[1]), 6);

        // Taken branch, two flush cycles
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("br0_ff_a", int'(ff[0]), 1);
        chk("br0_en_a", int'(en[0]), 15);
        idle(1);
        chk("br1_ff_a", int'(ff[0]), 1);
        chk("br1_state_a", int'(st[0]), 2);
        idle(1);
        chk("br2_ff_a", int'(ff[0]), 0);
        idle(1);
        chk("br_sc_a", int'(sc[0]), 2);

        // D-cache block over a pending branch
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
            chk("dc_en_a", int'(en[0]), 0);
        end
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("dc_rel_state_a", int'(st[0]), 3);
        chk("dc_rel_ff_a", int'(ff[0]), 1);
        chk("dc_rel_en_a", int'(en[0]), 15);
        chk("dc_sc_a", int'(sc[0]), 6);
        chk("dc_sc_b", int'(sc[1]), 10);
        idle(3);

        // D-cache block interrupting a load-use stall
        cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("dc_lu_resume_b", int'(en[1][3]), 0);
        idle(3);

        // I-cache block, then I-cache coincident with branch
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("ic_nop_a", int'(nop[0]), 1);
            chk("ic_fetch_a", int'(en[0][3]), 0);
        end
        idle(1);
        chk("ic_rel_state_a", int'(st[0]), 4);
        chk("ic_rel_nop_a", int'(nop[0]), 0);
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ic_br_ff_a", int'(ff[0]), 1);
        chk("ic_br_fetch_a", int'(en[0][3]), 1);
        idle(3);

        // Async reset while instance b sits in LU_STALL
        cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("pre_rst_state_b", int'(st[1]), 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_en_b", int'(en[1]), 0);
        chk("async_fd_b", int'(fd[1]), 0);
        chk("async_state_b", int'(st[1]), 0);
        chk("async_sc_b", int'(sc[1]), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        idle(1);
        chk("post_rst_state_b", int'(st[1]), 0);
        chk("post_rst_en_b", int'(en[1]), 15);

        // Long fetch stall to saturate the counter
        for (int i = 0; i < 65540; i++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sat_sc_a", int'(sc[0]), 65535);
        chk("sat_sc_b", int'(sc[1]), 65535);
        idle(2);
        chk("sat_hold_a", int'(sc[0]), 65535);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
